nibble_add_sched: RTL and testbench
===================================

NIBBLE_ADD_SCHED -- requirements
Module: nibble_add_sched

Interface
REQ-001 Parameter NIBBLES, default 4, meaning: operand width W = 4*NIBBLES bits; legal values 2..8.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0, req1  input  1 each  request from requester 0 / 1; held high until granted.
REQ-005 a0, b0, a1, b1  input  W each  operands of requester 0 / 1; valid while the matching req is high.
REQ-006 sub0, sub1  input  1 each  op select: 0 = a+b, 1 = a-b.
REQ-007 gnt0, gnt1  output  1 each  one-cycle grant; operands of that requester are captured on that clock edge.
REQ-008 busy  output  1  high whenever the FSM is not IDLE.
REQ-009 done  output  1  one-cycle pulse; result fields are valid from this cycle on.
REQ-010 done_id  output  1  requester index of the completed operation.
REQ-011 result  output  W  sum or difference, modulo 2^W.
REQ-012 cout  output  1  final carry out (for subtract: 1 = no borrow, a >= b unsigned).
REQ-013 ovf  output  1  two's-complement overflow of the operation.

Function
REQ-014 Datapath: one 4-bit ripple-carry adder (codebase 4-bit adder cell) plus a 1-bit carry register, reused once per nibble; no W-bit adder.
REQ-015 FSM states: IDLE, CALC, DONE; IDLE->CALC on any grant; CALC->DONE after nibble NIBBLES-1; DONE->IDLE unconditionally.
REQ-016 Grant: combinational, asserted only in IDLE; at most one of gnt0/gnt1 high in any cycle.
REQ-017 Arbitration: round-robin. If only one req is high, grant it. If both are high, grant the requester not served last; "last served" resets to 1, so req0 wins the first tie.
REQ-018 On the grant edge, latch a, b^{W{sub}}, sub and requester id. Initialise the carry register to sub and the nibble index k to 0.
REQ-019 CALC cycle k: add nibble k of a, nibble k of b', and the carry; store the 4-bit sum into result-staging nibble k and the carry out into the carry register; k increments.
REQ-020 On the CALC->DONE edge, update result, cout and done_id.
REQ-021 ovf = (a[W-1] == b'[W-1]) & (result[W-1] != a[W-1]).
REQ-022 In DONE, done = 1 for exactly one cycle.
REQ-023 result, cout, ovf and done_id hold until the next DONE.
REQ-024 Latency: if a grant occurs in cycle 0, done is high in cycle NIBBLES+1; the earliest next grant is cycle NIBBLES+2.
REQ-025 Requests high during CALC or DONE are not granted and are not lost; they are arbitrated on return to IDLE.
REQ-026 A requester drops req after its grant. If req stays high, it is treated as a new request, subject to round-robin.
REQ-027 No grant, done or busy may be asserted with both req low in IDLE.

Reset
REQ-028 rst_n low asynchronously forces: state = IDLE; k = 0; carry = 0; last-served = 1; result, staging, cout, ovf and done_id = 0. Combinationally, gnt0/gnt1, busy and done = 0.
REQ-029 Reset during CALC or DONE discards the operation; no done pulse is produced for it.
REQ-030 After rst_n rises, the first rising edge may grant.

Verification (NIBBLES=4)
REQ-031 req0, a0=0x1234, b0=0x0FFF, sub0=0 -> gnt0 in cycle 0, busy cycles 1-5, done in cycle 5, result=0x2233, cout=0, ovf=0, done_id=0.
REQ-032 req1, a1=0x0005, b1=0x0007, sub1=1 -> result=0xFFFE, cout=0, ovf=0, done_id=1.
REQ-033 Boundary checks:
- 0x7FFF+0x0001 -> result=0x8000, ovf=1, cout=0.
- 0xFFFF+0x0001 -> result=0x0000, cout=1, ovf=0.
- 0x8000-0x0001 -> result=0x7FFF, ovf=1, cout=1.
REQ-034 req0 and req1 held high from reset release -> grants in order 0,1,0,1, spaced 6 cycles apart; done_id follows the same order.
REQ-035 req1 raised during CALC -> no gnt1 until IDLE; gnt1 in the cycle after done.
REQ-036 rst_n pulsed low during CALC k=2 -> all outputs 0 immediately, no done. After release, req0 with 0x0001+0x0001 -> result=0x0002 in 5 cycles.

Source files
------------

// File: rtl/nibble_add_sched.sv
`timescale 1ns/1ps
// Two-requester add/subtract unit that reuses one 4-bit ripple adder
// over NIBBLES cycles, with a round-robin grant and a one-cycle done.

module nibble_add_cell (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  // Four chained full adders, carry rippling from bit 0 upward
  always_comb begin
    logic [4:0] c;
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[4];
  end

endmodule

module nibble_add_sched #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [4*NIBBLES-1:0] a0,
  input  logic [4*NIBBLES-1:0] b0,
  input  logic [4*NIBBLES-1:0] a1,
  input  logic [4*NIBBLES-1:0] b1,
  input  logic                 sub0,
  input  logic                 sub1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 busy,
  output logic                 done,
  output logic                 done_id,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
  output logic                 ovf
);

  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic           carry_q, carry_d;
  logic           last_q, last_d;
  logic           id_q, id_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   stage_q, stage_d;
  logic [W-1:0]   result_q, result_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;
  logic           done_id_q, done_id_d;

  logic           idle;
  logic           pick1;
  logic           sub_sel;
  logic [3:0]     an, bn, nsum;
  logic           ncout;

  // Round-robin grant: on a tie, serve the requester not served last
  always_comb begin
    idle  = (state_q == IDLE) && rst_n;
    pick1 = req1 & (~req0 | ~last_q);
    gnt1  = idle & pick1;
    gnt0  = idle & req0 & ~pick1;
  end

  // Select the operand nibbles for the current step
  always_comb begin
    an = '0;
    bn = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (k_q == KW'(i)) begin
        an = a_q[i*4 +: 4];
        bn = b_q[i*4 +: 4];
      end
    end
  end

  nibble_add_cell u_cell (
    .a    (an),
    .b    (bn),
    .cin  (carry_q),
    .sum  (nsum),
    .cout (ncout)
  );

  // Next-state, operand capture and per-nibble accumulation
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    carry_d   = carry_q;
    last_d    = last_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    stage_d   = stage_q;
    result_d  = result_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    done_id_d = done_id_q;
    sub_sel   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt0 | gnt1) begin
          sub_sel = gnt1 ? sub1 : sub0;
          a_d     = gnt1 ? a1 : a0;
          b_d     = (gnt1 ? b1 : b0) ^ {W{sub_sel}};
          id_d    = gnt1;
          last_d  = gnt1;
          carry_d = sub_sel;
          k_d     = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (k_q == KW'(i)) stage_d[i*4 +: 4] = nsum;
        end
        carry_d = ncout;
        k_d     = k_q + 1'b1;
        if (k_q == KLAST) begin
          k_d       = '0;
          result_d  = stage_d;
          cout_d    = ncout;
          ovf_d     = (a_q[W-1] == b_q[W-1]) & (nsum[3] != a_q[W-1]);
          done_id_d = id_q;
          state_d   = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      carry_q   <= 1'b0;
      last_q    <= 1'b1;
      id_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      stage_q   <= '0;
      result_q  <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      carry_q   <= carry_d;
      last_q    <= last_d;
      id_q      <= id_d;
      a_q       <= a_d;
      b_q       <= b_d;
      stage_q   <= stage_d;
      result_q  <= result_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
      done_id_q <= done_id_d;
    end
  end

  // Status and result outputs
  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    result  = result_q;
    cout    = cout_q;
    ovf     = ovf_q;
    done_id = done_id_q;
  end

endmodule

// File: tb/tb_nibble_add_sched.sv
`timescale 1ns/1ps
// Bench for nibble_add_sched (NIBBLES=4): scoreboarded results
// plus grant, latency, arbitration and reset behaviour.

module tb_nibble_add_sched;

  typedef struct packed {
    logic [15:0] r;
    logic        c;
    logic        o;
    logic        id;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, sub0, sub1;
  logic [15:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, busy, done, done_id;
  logic [15:0] result;
  logic        cout, ovf;

  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  exp_t mon_e;

  nibble_add_sched #(.NIBBLES(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0),
    .req1    (req1),
    .a0      (a0),
    .b0      (b0),
    .a1      (a1),
    .b1      (b1),
    .sub0    (sub0),
    .sub1    (sub1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .result  (result),
    .cout    (cout),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic id, input logic [15:0] a,
                                 input logic [15:0] b, input logic sub);
    exp_t        e;
    logic [15:0] bp;
    logic [16:0] s;
    bp   = b ^ {16{sub}};
    s    = {1'b0, a} + {1'b0, bp} + {16'd0, sub};
    e.r  = s[15:0];
    e.c  = s[16];
    e.o  = (a[15] == bp[15]) & (s[15] != a[15]);
    e.id = id;
    return e;
  endfunction

  // Scoreboard: every done pops one expected result
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done got done=1 want no pending op");
      end else begin
        mon_e = q.pop_front();
        checks++;
        if (result !== mon_e.r) begin
          failures++;
          $display("FAIL result got %h want %h", result, mon_e.r);
        end
        checks++;
        if (cout !== mon_e.c) begin
          failures++;
          $display("FAIL cout got %b want %b (r=%h)", cout, mon_e.c, mon_e.r);
        end
        checks++;
        if (ovf !== mon_e.o) begin
          failures++;
          $display("FAIL ovf got %b want %b (r=%h)", ovf, mon_e.o, mon_e.r);
        end
        checks++;
        if (done_id !== mon_e.id) begin
          failures++;
          $display("FAIL done_id got %b want %b", done_id, mon_e.id);
        end
      end
    end
  end

  task automatic run_op(input logic id, input logic [15:0] a,
                        input logic [15:0] b, input logic sub,
                        input exp_t e);
    int dc;
    bit busy_ok;
    @(posedge clk); #1;
    if (id) begin
      req1 = 1'b1; a1 = a; b1 = b; sub1 = sub;
    end else begin
      req0 = 1'b1; a0 = a; b0 = b; sub0 = sub;
    end
    @(negedge clk);
    checks++;
    if ({gnt1, gnt0} !== (id ? 2'b10 : 2'b01)) begin
      failures++;
      $display("FAIL grant got %b%b want id %0d", gnt1, gnt0, id);
    end
    q.push_back(e);
    dc = 0;
    busy_ok = 1'b1;
    for (int n = 1; n <= 12 && dc == 0; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) dc = n;
    end
    checks++;
    if (dc != 5) begin
      failures++;
      $display("FAIL latency got %0d want 5", dc);
    end
    checks++;
    if (!busy_ok) begin
      failures++;
      $display("FAIL busy_window got low want high in cycles 1-5");
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_after got %b want 0", busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; sub0 = 1'b0; sub1 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({gnt0, gnt1, busy, done} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctrl got %b want 0000", {gnt0, gnt1, busy, done});
    end
    checks++;
    if ({result, cout, ovf, done_id} !== 19'd0) begin
      failures++;
      $display("FAIL reset_data got %h want 0", {result, cout, ovf, done_id});
    end
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1, busy, done} !== 4'b0) begin
        failures++;
        $display("FAIL idle got %b want 0000", {gnt0, gnt1, busy, done});
      end
    end
  endtask

  task automatic test_basic();
    run_op(1'b0, 16'h1234, 16'h0FFF, 1'b0, '{16'h2233, 1'b0, 1'b0, 1'b0});
    run_op(1'b1, 16'h0005, 16'h0007, 1'b1, '{16'hFFFE, 1'b0, 1'b0, 1'b1});
  endtask

  task automatic test_boundary();
    run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0});
    run_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b1});
    run_op(1'b0, 16'h8000, 16'h0001, 1'b1, '{16'h7FFF, 1'b1, 1'b1, 1'b0});
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    logic        s, id;
    for (int i = 0; i < 6; i++) begin
      a  = 16'($urandom);
      b  = 16'($urandom);
      s  = 1'($urandom_range(0, 1));
      id = 1'($urandom_range(0, 1));
      run_op(id, a, b, s, model(id, a, b, s));
    end
  endtask

  task automatic test_round_robin();
    int ng;
    int at[4];
    logic [3:0] ids;
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b1; a0 = 16'h0102; b0 = 16'h0304; sub0 = 1'b0;
    req1 = 1'b1; a1 = 16'h1000; b1 = 16'h0001; sub1 = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ng = 0;
    ids = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if ((gnt0 | gnt1) && ng < 4) begin
        checks++;
        if (gnt0 & gnt1) begin
          failures++;
          $display("FAIL rr_onehot got gnt0=1 gnt1=1 want one");
        end
        ids[ng] = gnt1;
        at[ng]  = c;
        q.push_back(gnt1 ? model(1'b1, a1, b1, sub1)
                         : model(1'b0, a0, b0, sub0));
        ng++;
      end
      @(posedge clk); #1;
      if (ng == 4) begin
        req0 = 1'b0; req1 = 1'b0;
      end
    end
    checks++;
    if (ng != 4 || ids !== 4'b1010) begin
      failures++;
      $display("FAIL rr_order got n=%0d ids=%b want 4 ids=1010", ng, ids);
    end
    checks++;
    if (at[0] != 0 || at[1] != 6 || at[2] != 12 || at[3] != 18) begin
      failures++;
      $display("FAIL rr_spacing got %0d %0d %0d %0d want 0 6 12 18",
               at[0], at[1], at[2], at[3]);
    end
  endtask

  task automatic test_late_req();
    int  dc, g1;
    bit  early;
    @(posedge clk); #1;
    req0 = 1'b1; a0 = 16'h00FF; b0 = 16'h0001; sub0 = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1) begin
      failures++;
      $display("FAIL late_gnt0 got %b want 1", gnt0);
    end
    q.push_back(model(1'b0, a0, b0, sub0));
    dc = 0; g1 = 0; early = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n == 1) req0 = 1'b0;
      if (n == 2) begin
        req1 = 1'b1; a1 = 16'h4000; b1 = 16'h4000; sub1 = 1'b0;
      end
      if (g1 != 0 && n == g1 + 1) req1 = 1'b0;
      @(negedge clk);
      if (done === 1'b1 && dc == 0) dc = n;
      if (gnt1 === 1'b1 && dc == 0) early = 1'b1;
      if (gnt1 === 1'b1 && g1 == 0) begin
        g1 = n;
        q.push_back(model(1'b1, a1, b1, sub1));
      end
    end
    checks++;
    if (early) begin
      failures++;
      $display("FAIL late_early got gnt1 before done want none");
    end
    checks++;
    if (g1 != 6) begin
      failures++;
      $display("FAIL late_gnt1 got cycle %0d want 6", g1);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    req0 = 1'b1; a0 = 16'h1111; b0 = 16'h2222; sub0 = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1) begin
      failures++;
      $display("FAIL mid_gnt0 got %b want 1", gnt0);
    end
    for (int n = 1; n <= 3; n++) begin
      @(posedge clk); #1;
      if (n == 1) req0 = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt0, gnt1, busy, done} !== 4'b0) begin
      failures++;
      $display("FAIL mid_ctrl got %b want 0000", {gnt0, gnt1, busy, done});
    end
    checks++;
    if ({result, cout, ovf, done_id} !== 19'd0) begin
      failures++;
      $display("FAIL mid_data got %h want 0", {result, cout, ovf, done_id});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(1'b0, 16'h0001, 16'h0001, 1'b0, '{16'h0002, 1'b0, 1'b0, 1'b0});
    repeat (8) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_basic();
    test_boundary();
    test_random();
    test_round_robin();
    test_late_req();
    test_reset_mid();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL pending got %0d ops want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
